// File: rtl/axis_param_fifo.sv
// axis_param_fifo: parametrised AXI-Stream FIFO, depth 2^ADDR_W, with
// first-word-fall-through output, fill level, packet count and packet mode.
//
// Ports:
//   clk, rst      - single clock, asynchronous active-high reset
//   s_tdata_in    - slave data            (DATA_W)
//   s_tvalid_in   - slave valid
//   s_last_in     - slave TLAST
//   s_tready_out  - slave ready (registered state only)
//   m_tdata_out   - master data (head of FIFO)
//   m_tvalid_out  - master valid
//   m_last_out    - master TLAST
//   m_tready_in   - master ready
//   level_out     - stored beats, 0..DEPTH (ADDR_W+1)
//   pkt_cnt_out   - stored complete packets, 0..DEPTH (ADDR_W+1)
module axis_param_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter bit PKT_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata_in,
  input  logic              s_tvalid_in,
  input  logic              s_last_in,
  output logic              s_tready_out,
  output logic [DATA_W-1:0] m_tdata_out,
  output logic              m_tvalid_out,
  output logic              m_last_out,
  input  logic              m_tready_in,
  output logic [ADDR_W:0]   level_out,
  output logic [ADDR_W:0]   pkt_cnt_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_FULL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LP_ONE =
    (ADDR_W+1)'(1);

  logic [DATA_W:0] r_mem [0:DEPTH-1];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_pkt_cnt;

  logic [ADDR_W:0] w_level;
  logic [DATA_W:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_push_last;
  logic            w_pop_last;

  // Extra pointer bit distinguishes full from empty.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LP_FULL);
  assign w_empty = (w_level == '0);
  assign w_head  = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // In packet mode the full term lets an oversize
  // packet drain instead of deadlocking.
  assign w_valid = !w_empty &&
    (!PKT_MODE || (r_pkt_cnt != '0) || w_full);

  assign w_push      = s_tvalid_in && !w_full;
  assign w_pop       = w_valid && m_tready_in;
  assign w_push_last = w_push && s_last_in;
  assign w_pop_last  = w_pop && w_head[DATA_W];

  assign s_tready_out = !w_full;
  assign m_tvalid_out = w_valid;
  assign m_tdata_out  = w_head[DATA_W-1:0];
  assign m_last_out   = w_head[DATA_W];
  assign level_out    = w_level;
  assign pkt_cnt_out  = r_pkt_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <=
        {s_last_in, s_tdata_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_ONE;
    end
  end

  // Saturate at zero: an oversize release may pop
  // a last beat that was never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_push_last && !w_pop_last) begin
      r_pkt_cnt <= r_pkt_cnt + LP_ONE;
    end else if (!w_push_last && w_pop_last &&
                 (r_pkt_cnt != '0)) begin
      r_pkt_cnt <= r_pkt_cnt - LP_ONE;
    end
  end

endmodule
